board_ram_arbiter: RTL and testbench



---
 rtl/board_ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_board_ram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Shares the 8x8 board state RAM between the read clients, the move-commit writer and the board-clear sequencer.
// Define BOARD_ARB_FIXED_PRIO_EN to replace the round-robin read arbiter with a fixed-priority one.
module board_ram_arbiter #(
  parameter int N_CLIENTS = 3,
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 2,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CLIENTS-1:0]           rd_req,
  input  logic [N_CLIENTS*ADDR_BITS-1:0] rd_addr,
  output logic [N_CLIENTS-1:0]           rd_gnt,
  output logic [N_CLIENTS-1:0]           rd_valid,
  output logic [DATA_BITS-1:0]           rd_data,
  input  logic                           wr_req,
  input  logic [ADDR_BITS-1:0]           wr_addr,
  input  logic [DATA_BITS-1:0]           wr_data,
  output logic                           wr_ack,
  input  logic                           clr_start,
  output logic                           clr_busy,
  output logic                           clr_done,
  output logic                           ram_we,
  output logic [ADDR_BITS-1:0]           ram_wr_addr,
  output logic [DATA_BITS-1:0]           ram_wr_data,
  output logic [ADDR_BITS-1:0]           ram_rd_addr,
  input  logic [DATA_BITS-1:0]           ram_rd_data
);

  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic                 clearing;
  logic                 arb_en;
  logic [PTR_W-1:0]     gnt_idx;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic [N_CLIENTS-1:0] vld_p [RD_LATENCY];

  // Clients and the writer are only served in IDLE, and a same-cycle clr_start takes priority.
  assign clearing = (state == S_CLEAR);
  assign arb_en   = rst_n && (state == S_IDLE) && !clr_start;
  assign clr_busy = (state != S_IDLE);
  assign clr_done = (state == S_DONE);

  assign wr_ack      = arb_en & wr_req;
  assign ram_we      = wr_ack | (rst_n & clearing);
  assign ram_wr_addr = clearing ? clr_cnt : (wr_ack ? wr_addr : '0);
  assign ram_wr_data = clearing ? CLEAR_VALUE : (wr_ack ? wr_data : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_start) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOARD_ARB_FIXED_PRIO_EN
  function automatic logic [N_CLIENTS-1:0] fixed_pick(input logic [N_CLIENTS-1:0] req);
    logic [N_CLIENTS-1:0] g;
    g = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) g = N_CLIENTS'(1) << i;
    end
    return g;
  endfunction

  assign rd_gnt = arb_en ? fixed_pick(rd_req) : '0;
`else
  logic [PTR_W-1:0] ptr;

  // Walk downward so the client just after the pointer is assigned last and therefore wins.
  function automatic logic [N_CLIENTS-1:0] rr_pick(input logic [N_CLIENTS-1:0] req,
                                                   input logic [PTR_W-1:0] p);
    logic [N_CLIENTS-1:0] g;
    logic [PTR_W-1:0]     idx;
    g = '0;
    for (int off = N_CLIENTS; off >= 1; off--) begin
      idx = PTR_W'((int'(p) + off) % N_CLIENTS);
      if (req[idx]) g = N_CLIENTS'(1) << idx;
    end
    return g;
  endfunction

  assign rd_gnt = arb_en ? rr_pick(rd_req, ptr) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= PTR_W'(N_CLIENTS - 1);
    else if (|rd_gnt) ptr <= gnt_idx;
  end
`endif

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (rd_gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign sel_addr    = rd_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
  assign ram_rd_addr = (|rd_gnt) ? sel_addr : rd_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)       rd_addr_q <= '0;
    else if (|rd_gnt) rd_addr_q <= sel_addr;
  end

  // Stage boundary: the one-hot grant follows the RAM read latency and becomes rd_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= '0;
    end else begin
      vld_p[0] <= rd_gnt;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign rd_valid = vld_p[RD_LATENCY-1];
  assign rd_data  = (|rd_valid) ? ram_rd_data : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter with a behavioural RAM and a queue-based reference model.
module tb_board_ram_arbiter;
  localparam int N   = 3;
  localparam int AW  = 6;
  localparam int DW  = 2;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt, rd_valid;
  logic [DW-1:0]   rd_data;
  logic            wr_req, wr_ack;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            clr_start, clr_busy, clr_done;
  logic            ram_we;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]   ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  board_ram_arbiter #(.N_CLIENTS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .RD_LATENCY(LAT),
                      .CLEAR_VALUE(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data));

  // Board RAM: read-before-write, LAT-cycle read latency.
  logic [DW-1:0] ram   [64];
  logic [DW-1:0] ram_q [LAT];
  always @(posedge clk) begin
    if (ram_we) ram[ram_wr_addr] <= ram_wr_data;
    ram_q[0] <= ram[ram_rd_addr];
    for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign ram_rd_data = ram_q[LAT-1];

  // Reference model
  typedef struct { int client; int data; int due; } pend_t;
  pend_t pend [$];
  int mem_m [64];
  int last_win = N - 1;
  int clr_pos = -1;
  int last_raddr = 0;
  int cyc = 0;
  int e_win = -1;
  logic [N-1:0]  e_gnt = '0, e_valid = '0;
  logic          e_ack = 1'b0, e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [AW-1:0] e_waddr = '0, e_raddr = '0;
  logic [DW-1:0] e_wdata = '0, e_data = '0;

  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] v [3];

  task automatic model_eval();
    logic free, clr_w;
    int c;
    e_busy = (clr_pos >= 0);
    e_done = (clr_pos == 64);
    free   = rst_n && (clr_pos < 0) && !clr_start;
    clr_w  = rst_n && (clr_pos >= 0) && (clr_pos < 64);
    e_ack  = free && wr_req;
    e_we   = clr_w || e_ack;
    e_waddr = clr_w ? AW'(clr_pos) : (e_ack ? wr_addr : '0);
    e_wdata = clr_w ? 2'b00 : (e_ack ? wr_data : '0);
    e_win = -1;
    e_gnt = '0;
    if (free) begin
      for (int k = 1; k <= N; k++) begin
`ifdef BOARD_ARB_FIXED_PRIO_EN
        c = k - 1;
`else
        c = (last_win + k) % N;
`endif
        if (e_win < 0 && rd_req[c]) e_win = c;
      end
    end
    if (e_win >= 0) begin
      e_gnt[e_win] = 1'b1;
      e_raddr = rd_addr[e_win*AW +: AW];
    end else begin
      e_raddr = AW'(last_raddr);
    end
    e_valid = '0;
    e_data  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_valid[pend[0].client] = 1'b1;
      e_data = DW'(pend[0].data);
    end
  endtask

  task automatic model_commit();
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (e_win >= 0) begin
      pend.push_back('{client: e_win, data: mem_m[e_raddr], due: cyc + LAT});
      last_win   = e_win;
      last_raddr = int'(e_raddr);
    end
    if (e_we) mem_m[e_waddr] = int'(e_wdata);
    if (!rst_n) begin
      clr_pos = -1; last_win = N - 1; last_raddr = 0; pend.delete();
    end else if (clr_pos < 0) begin
      if (clr_start) clr_pos = 0;
    end else if (clr_pos == 64) begin
      clr_pos = -1;
    end else begin
      clr_pos++;
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0;
    settle(); tick(); settle(); tick();
    rst_n = 1'b1;
    settle();
    n_checks++; if (rd_gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", rd_gnt); else n_pass++;
    n_checks++; if (rd_valid !== 3'b000) $display("FAIL reset_valid: got %b expected 000", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 2'b00) $display("FAIL reset_data: got %b expected 00", rd_data); else n_pass++;
    n_checks++; if (wr_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", wr_ack); else n_pass++;
    n_checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL reset_clr: got busy=%b done=%b expected 0/0", clr_busy, clr_done); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", ram_we); else n_pass++;
    n_checks++; if (ram_rd_addr !== 6'd0) $display("FAIL reset_rdaddr: got %0h expected 0", ram_rd_addr); else n_pass++;
    tick();
  endtask

  task automatic test_clear();
    int we_cnt, busy_cnt, done_cnt, done_at;
    we_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    clr_start = 1'b1;
    settle();
    n_checks++; if (ram_we !== 1'b0) $display("FAIL clr_start_we: got %b expected 0", ram_we); else n_pass++;
    tick();
    clr_start = 1'b0;
    for (int j = 1; j <= 70; j++) begin
      settle();
      if (ram_we) we_cnt++;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = j; end
      if (j <= 64) begin
        n_checks++;
        if (ram_we !== 1'b1 || ram_wr_addr !== AW'(j - 1) || ram_wr_data !== 2'b00)
          $display("FAIL clr_write: got we=%b addr=%0d data=%b expected 1/%0d/00",
                   ram_we, ram_wr_addr, ram_wr_data, j - 1);
        else n_pass++;
      end
      n_checks++;
      if (clr_busy !== e_busy || clr_done !== e_done)
        $display("FAIL clr_state: got busy=%b done=%b expected %b/%b", clr_busy, clr_done, e_busy, e_done);
      else n_pass++;
      tick();
    end
    n_checks++; if (we_cnt != 64) $display("FAIL clr_we_count: got %0d expected 64", we_cnt); else n_pass++;
    n_checks++; if (busy_cnt != 65) $display("FAIL clr_busy_count: got %0d expected 65", busy_cnt); else n_pass++;
    n_checks++; if (done_cnt != 1 || done_at != 65)
      $display("FAIL clr_done_pulse: got count=%0d at=%0d expected 1 at 65", done_cnt, done_at); else n_pass++;
  endtask

  task automatic test_write_read();
    wr_req = 1'b1; wr_addr = 6'h1B; wr_data = 2'b01;
    settle();
    n_checks++; if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_wr_addr !== 6'h1B || ram_wr_data !== 2'b01)
      $display("FAIL wr_ack: got ack=%b we=%b addr=%0h data=%b expected 1/1/1b/01",
               wr_ack, ram_we, ram_wr_addr, ram_wr_data); else n_pass++;
    tick();
    wr_req = 1'b0; rd_req = 3'b010; rd_addr = {6'd0, 6'h1B, 6'd0};
    settle();
    n_checks++; if (rd_gnt !== 3'b010 || ram_rd_addr !== 6'h1B)
      $display("FAIL rd_gnt1: got gnt=%b addr=%0h expected 010/1b", rd_gnt, ram_rd_addr); else n_pass++;
    tick();
    rd_req = '0;
    settle();
    n_checks++; if (rd_valid !== 3'b010 || rd_data !== 2'b01)
      $display("FAIL rd_ret1: got valid=%b data=%b expected 010/01", rd_valid, rd_data); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g, prev_g;
    rst_n = 1'b0; settle(); tick(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v[k] = DW'($urandom_range(1, 3));
      wr_req = 1'b1; wr_addr = AW'(5 + k); wr_data = v[k];
      settle();
      n_checks++; if (wr_ack !== 1'b1) $display("FAIL rr_setup_ack: got %b expected 1", wr_ack); else n_pass++;
      tick();
    end
    wr_req = 1'b0; rd_req = 3'b111; rd_addr = {6'd7, 6'd6, 6'd5};
    prev_g = '0;
    for (int k = 0; k <= 6; k++) begin
      settle();
`ifdef BOARD_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (k % 3);
`endif
      if (k < 6) begin
        n_checks++; if (rd_gnt !== exp_g) $display("FAIL rr_gnt: got %b expected %b", rd_gnt, exp_g); else n_pass++;
      end
      if (k >= 1) begin
        n_checks++;
        if (rd_valid !== prev_g || rd_data !== v[prev_g == 3'b001 ? 0 : (prev_g == 3'b010 ? 1 : 2)])
          $display("FAIL rr_ret: got valid=%b data=%b expected valid=%b", rd_valid, rd_data, prev_g);
        else n_pass++;
      end
      prev_g = exp_g;
      tick();
      if (k == 5) rd_req = '0;
    end
  endtask

  task automatic test_clear_vs_write();
    rd_req = 3'b100; rd_addr = {6'd7, 6'd6, 6'd5};
    settle();
    n_checks++; if (rd_gnt !== 3'b100) $display("FAIL cw_pre_gnt: got %b expected 100", rd_gnt); else n_pass++;
    tick();
    rd_req = 3'b001; clr_start = 1'b1; wr_req = 1'b1; wr_addr = 6'h2A; wr_data = 2'b10;
    settle();
    n_checks++; if (wr_ack !== 1'b0 || rd_gnt !== 3'b000)
      $display("FAIL cw_collide: got ack=%b gnt=%b expected 0/000", wr_ack, rd_gnt); else n_pass++;
    n_checks++; if (rd_valid !== 3'b100 || rd_data !== v[2])
      $display("FAIL cw_inflight: got valid=%b data=%b expected 100/%b", rd_valid, rd_data, v[2]); else n_pass++;
    tick();
    clr_start = 1'b0;
    for (int j = 0; j <= 64; j++) begin
      settle();
      n_checks++;
      if (wr_ack !== 1'b0 || rd_gnt !== 3'b000 || clr_busy !== 1'b1 || clr_done !== (j == 64))
        $display("FAIL cw_during: got ack=%b gnt=%b busy=%b done=%b at step %0d",
                 wr_ack, rd_gnt, clr_busy, clr_done, j);
      else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (wr_ack !== 1'b1 || rd_gnt !== 3'b001 || clr_busy !== 1'b0 || ram_wr_addr !== 6'h2A)
      $display("FAIL cw_after: got ack=%b gnt=%b busy=%b addr=%0h expected 1/001/0/2a",
               wr_ack, rd_gnt, clr_busy, ram_wr_addr); else n_pass++;
    tick();
    wr_req = 1'b0; rd_req = '0;
    settle();
    n_checks++; if (rd_valid !== 3'b001 || rd_data !== 2'b00)
      $display("FAIL cw_read_cleared: got valid=%b data=%b expected 001/00", rd_valid, rd_data); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    wr_req = 1'b1; wr_addr = 6'd3; wr_data = 2'b10;
    settle(); tick();
    wr_addr = 6'd30; wr_data = 2'b11;
    settle(); tick();
    wr_req = 1'b0; clr_start = 1'b1;
    settle(); tick();
    clr_start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      settle();
      n_checks++; if (ram_wr_addr !== AW'(j)) $display("FAIL mid_addr: got %0d expected %0d", ram_wr_addr, j); else n_pass++;
      tick();
    end
    rst_n = 1'b0;
    settle();
    n_checks++; if (ram_we !== e_we) $display("FAIL mid_rst_we: got %b expected %b", ram_we, e_we); else n_pass++;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 70; j++) begin
      settle();
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL mid_abort: got %0d busy/done cycles expected 0", bad); else n_pass++;
    rd_req = 3'b011; rd_addr = {6'd0, 6'd30, 6'd3};
    settle();
    n_checks++; if (rd_gnt !== 3'b001) $display("FAIL mid_gnt0: got %b expected 001", rd_gnt); else n_pass++;
    tick();
    rd_req = 3'b010;
    settle();
    n_checks++; if (rd_gnt !== 3'b010) $display("FAIL mid_gnt1: got %b expected 010", rd_gnt); else n_pass++;
    n_checks++; if (rd_valid !== 3'b001 || rd_data !== 2'b00)
      $display("FAIL mid_cleared_cell: got valid=%b data=%b expected 001/00", rd_valid, rd_data); else n_pass++;
    tick();
    rd_req = '0;
    settle();
    n_checks++; if (rd_valid !== 3'b010 || rd_data !== 2'b11)
      $display("FAIL mid_kept_cell: got valid=%b data=%b expected 010/11", rd_valid, rd_data); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      rd_req    = N'($urandom_range(0, 7));
      rd_addr   = (N*AW)'({$urandom, $urandom});
      wr_req    = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      clr_start = ($urandom_range(0, 149) == 0);
      settle();
      n_checks++; if (rd_gnt !== e_gnt) $display("FAIL rand_gnt: got %b expected %b", rd_gnt, e_gnt); else n_pass++;
      n_checks++; if (ram_rd_addr !== e_raddr) $display("FAIL rand_rdaddr: got %0h expected %0h", ram_rd_addr, e_raddr); else n_pass++;
      n_checks++; if (wr_ack !== e_ack || ram_we !== e_we)
        $display("FAIL rand_wr: got ack=%b we=%b expected %b/%b", wr_ack, ram_we, e_ack, e_we); else n_pass++;
      if (e_we) begin
        n_checks++; if (ram_wr_addr !== e_waddr || ram_wr_data !== e_wdata)
          $display("FAIL rand_wport: got %0h/%b expected %0h/%b", ram_wr_addr, ram_wr_data, e_waddr, e_wdata); else n_pass++;
      end
      n_checks++; if (rd_valid !== e_valid || rd_data !== e_data)
        $display("FAIL rand_ret: got %b/%b expected %b/%b", rd_valid, rd_data, e_valid, e_data); else n_pass++;
      n_checks++; if (clr_busy !== e_busy || clr_done !== e_done)
        $display("FAIL rand_clr: got %b/%b expected %b/%b", clr_busy, clr_done, e_busy, e_done); else n_pass++;
      tick();
    end
    rd_req = '0; wr_req = 1'b0; clr_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_round_robin();
    test_clear_vs_write();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
